// File: rtl/five_bit_down_counter_pkg.sv
// Shared constants for the five-bit down counter.
//   COUNT_W    : counter width in bits
//   COUNT_MAX  : value reached when decrementing past zero in wrap mode
//   COUNT_ZERO : reset / terminal value
package five_bit_down_counter_pkg;

  localparam int               COUNT_W    = 5;
  localparam logic [COUNT_W-1:0] COUNT_MAX  = 5'd31;
  localparam logic [COUNT_W-1:0] COUNT_ZERO = 5'd0;

endpackage

// File: rtl/five_bit_down_counter_bit.sv
// One counter bit: a single flop behind a prioritised select mux.
// Ports:
//   clk : rising-edge clock
//   clr : synchronous clear (same effect as rst; tied low by the counter)
//   rst : synchronous active-high reset, forces q to 0
//   ld  : load d into q
//   d   : load data
//   en  : borrow-enable, toggles q
//   q   : registered bit
// Priority: rst/clr, then ld, then en, otherwise hold.
module down_counter_bit (
  input  logic clk,
  input  logic clr,
  input  logic rst,
  input  logic ld,
  input  logic d,
  input  logic en,
  output logic q
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= 1'b0;
    end else if (ld) begin
      q <= d;
    end else if (en) begin
      q <= ~q;
    end
  end

endmodule

// File: rtl/five_bit_down_counter_cells.sv
// Small AND gate cells used to build the borrow chain and the done decode.
//   And      : y = a & b
//   ThreeAnd : y = a & b & c
//   FourAnd  : y = a & b & c & d
module And (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a & b;
endmodule

module ThreeAnd (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic y
);
  assign y = a & b & c;
endmodule

module FourAnd (
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  output logic y
);
  assign y = a & b & c & d;
endmodule

// File: rtl/five_bit_down_counter.sv
// Five-bit loadable down counter built from per-bit mux-flops and a gate-level
// borrow chain, with zero / terminal-count flags and a registered done pulse.
// Parameters:
//   WRAP : 1 = decrementing from 0 wraps to 31; 0 = count holds at 0
// Ports:
//   clk          : rising-edge clock
//   reset        : synchronous active-high reset (count -> 0, done -> 0)
//   load         : load load_value on the next edge (beats count_enable)
//   load_value   : preset value
//   count_enable : decrement on the next edge
//   count        : registered counter value
//   zero         : combinational, count == 0
//   tc           : combinational, count_enable & zero (for cascading)
//   done         : registered one-cycle pulse when a decrement reaches 0
module five_bit_down_counter
  import five_bit_down_counter_pkg::*;
#(
  parameter bit WRAP = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [COUNT_W-1:0] load_value,
  input  logic               count_enable,
  output logic [COUNT_W-1:0] count,
  output logic               zero,
  output logic               tc,
  output logic               done
);

  logic [COUNT_W-1:0] count_n;   // inverted bits feed the borrow chain
  logic [COUNT_W-1:0] toggle;    // per-bit borrow-enable
  logic               en_eff;    // count_enable after optional zero gating
  logic               low3_zero; // en_eff & bits [1:0] zero, first stage for bit 4
  logic               ce_no_load;
  logic               upper_zero;
  logic               detect;

  assign count_n = ~count;
  assign zero    = (count == COUNT_ZERO);
  assign tc      = count_enable & zero;

  // In hold mode the decrement is suppressed at zero, so the chain never
  // produces the 0 -> 31 borrow.
  generate
    if (WRAP) begin : g_wrap
      assign en_eff = count_enable;
    end else begin : g_hold
      And u_gate (.a(count_enable), .b(~zero), .y(en_eff));
    end
  endgenerate

  // Borrow chain: bit i toggles when decrementing and all lower bits are 0.
  assign toggle[0] = en_eff;
  And      u_t1  (.a(en_eff), .b(count_n[0]), .y(toggle[1]));
  ThreeAnd u_t2  (.a(en_eff), .b(count_n[0]), .c(count_n[1]), .y(toggle[2]));
  FourAnd  u_t3  (.a(en_eff), .b(count_n[0]), .c(count_n[1]), .d(count_n[2]),
                  .y(toggle[3]));
  ThreeAnd u_t4a (.a(en_eff), .b(count_n[0]), .c(count_n[1]), .y(low3_zero));
  ThreeAnd u_t4b (.a(low3_zero), .b(count_n[2]), .c(count_n[3]), .y(toggle[4]));

  generate
    for (genvar i = 0; i < COUNT_W; i++) begin : g_bit
      down_counter_bit u_bit (
        .clk (clk),
        .clr (1'b0),
        .rst (reset),
        .ld  (load),
        .d   (load_value[i]),
        .en  (toggle[i]),
        .q   (count[i])
      );
    end
  endgenerate

  // done fires only for a real decrement from 1; loads and wraps never
  // match this decode because they need count==1 with load low.
  And      u_nl  (.a(count_enable), .b(~load), .y(ce_no_load));
  FourAnd  u_one (.a(count_n[4]), .b(count_n[3]), .c(count_n[2]), .d(count_n[1]),
                  .y(upper_zero));
  ThreeAnd u_det (.a(upper_zero), .b(count[0]), .c(ce_no_load), .y(detect));

  // Always-load flop: reset clears it, otherwise it captures detect each edge.
  down_counter_bit u_done (
    .clk (clk),
    .clr (1'b0),
    .rst (reset),
    .ld  (1'b1),
    .d   (detect),
    .en  (1'b0),
    .q   (done)
  );

endmodule

// File: tb/tb_five_bit_down_counter.sv
// Bench for five_bit_down_counter: one wrapping and one holding instance share
// stimulus; reference models predict count/done and a monitor checks them.
module tb_five_bit_down_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       load = 1'b0;
  logic [4:0] load_value = 5'd0;
  logic       count_enable = 1'b0;

  logic [4:0] count_w, count_s;
  logic       zero_w, zero_s, tc_w, tc_s, done_w, done_s;

  int checks = 0;
  int errors = 0;

  // {done, count} expected after each edge
  logic [5:0] exp_w_q[$];
  logic [5:0] exp_s_q[$];

  // reference model state (-1 = unknown before first reset)
  int m_w = -1;
  int m_s = -1;

  always #5 clk = ~clk;

  five_bit_down_counter #(.WRAP(1'b1)) dut_w (
    .clk(clk), .reset(reset), .load(load), .load_value(load_value),
    .count_enable(count_enable), .count(count_w), .zero(zero_w), .tc(tc_w),
    .done(done_w)
  );

  five_bit_down_counter #(.WRAP(1'b0)) dut_s (
    .clk(clk), .reset(reset), .load(load), .load_value(load_value),
    .count_enable(count_enable), .count(count_s), .zero(zero_s), .tc(tc_s),
    .done(done_s)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Next value from the behavioural rules.
  function automatic int model_next(input int cur, input bit wrap, input bit r,
                                    input bit l, input int lv, input bit ce);
    if (r) return 0;
    if (l) return lv;
    if (ce) begin
      if (cur == 0) return wrap ? 31 : 0;
      return cur - 1;
    end
    return cur;
  endfunction

  // Drive one cycle of inputs, check the combinational flags before the
  // edge, and queue the expected registered response.
  task automatic step(input bit r, input bit l, input int lv, input bit ce);
    logic d_w, d_s;
    @(negedge clk);
    reset = r;
    load = l;
    load_value = 5'(lv);
    count_enable = ce;
    #1;
    if (m_w >= 0) begin
      check("zero_w", 8'(zero_w), 8'(m_w == 0));
      check("tc_w",   8'(tc_w),   8'(ce && m_w == 0));
    end
    if (m_s >= 0) begin
      check("zero_s", 8'(zero_s), 8'(m_s == 0));
      check("tc_s",   8'(tc_s),   8'(ce && m_s == 0));
    end
    d_w = !r && !l && ce && (m_w == 1);
    d_s = !r && !l && ce && (m_s == 1);
    m_w = (m_w < 0 && !r && !l) ? -1 : model_next(m_w, 1'b1, r, l, lv, ce);
    m_s = (m_s < 0 && !r && !l) ? -1 : model_next(m_s, 1'b0, r, l, lv, ce);
    if (m_w >= 0) exp_w_q.push_back({d_w, 5'(m_w)});
    if (m_s >= 0) exp_s_q.push_back({d_s, 5'(m_s)});
  endtask

  // Monitor: the registered outputs are valid one delta after every edge.
  always @(posedge clk) begin
    logic [5:0] e;
    #1;
    if (exp_w_q.size() > 0) begin
      e = exp_w_q.pop_front();
      check("count_w", 8'(count_w), 8'(e[4:0]));
      check("done_w",  8'(done_w),  8'(e[5]));
    end
    if (exp_s_q.size() > 0) begin
      e = exp_s_q.pop_front();
      check("count_s", 8'(count_s), 8'(e[4:0]));
      check("done_s",  8'(done_s),  8'(e[5]));
    end
  end

  initial begin
    // reset overrides a pending load
    step(1, 1, 17, 0);
    step(1, 1, 17, 1);
    step(0, 0, 0, 0);

    // load 5 and count down to 0
    step(0, 1, 5, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1);

    // at 0: wrap instance goes to 31 then back to 0 with done; hold instance stays
    for (int i = 0; i < 32; i++) step(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);

    // load beats enable, reset beats load
    step(0, 1, 3, 0);
    step(0, 1, 9, 1);
    step(1, 1, 9, 1);
    step(0, 0, 0, 0);

    // full borrow ripple, then hold with enable idle
    step(0, 1, 16, 0);
    step(0, 0, 0, 1);
    step(0, 1, 8, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);

    // load 0 must not pulse done; load 1 + one enable must
    step(0, 1, 0, 1);
    step(0, 1, 1, 0);
    step(0, 0, 0, 1);

    // reset mid-countdown
    step(0, 1, 2, 0);
    step(0, 0, 0, 1);
    step(1, 0, 0, 1);
    step(0, 0, 0, 1);

    // randomized traffic; load_value changes while load is low too
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0,
           int'($urandom_range(0, 31)), $urandom_range(0, 3) != 0);
    end

    step(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #2;
    check("queue_drained", 8'(exp_w_q.size() + exp_s_q.size()), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
